// File: rtl/rs_scan_ctrl_pkg.sv
// Shared types and constants for the RS_FF scan-chain controller.
package rs_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic OP_LOAD     = 1'b0;
    localparam logic OP_READBACK = 1'b1;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/rs_scan_ctrl_if.sv
// Host word streams: in_* carries chain data to the controller, out_* returns captured words.
interface rs_scan_ctrl_if #(
    parameter int unsigned WORD_W = 8
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/rs_scan_ctrl_crc16.sv
// Bit-serial CRC-16-CCITT; crc_next is the value after absorbing din this cycle.
module rs_scan_crc16
    import rs_scan_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc_next
);
    logic [15:0] crc;

    always_comb begin
        crc_next = {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC_POLY : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc_next;
        end
    end
endmodule

// File: rtl/rs_scan_ctrl.sv
// Scan-chain LOAD/READBACK controller for a chain of CHAIN_LEN RS_FF cells.
// Define RS_SCAN_CTRL_CRC_EN to check a CRC-16 of the loaded bitstream against crc_exp.
module rs_scan_ctrl
    import rs_scan_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned WORD_W    = 8
) (
    input  logic           CK,
    input  logic           R,
    input  logic           start,
    input  logic           op,
    input  logic           abort,
    rs_scan_ctrl_if.slave  host,
    output logic           SE,
    output logic           SI,
    input  logic           CHAIN_SO,
    output logic           SCAN_MODE,
    output logic           cfg_done,
    output logic           busy,
    output logic           done,
    output logic           err
`ifdef RS_SCAN_CTRL_CRC_EN
    ,
    input  logic [15:0]    crc_exp
`endif
);
    localparam int unsigned WORDS = CHAIN_LEN / WORD_W;
    localparam int unsigned CW    = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WCW   = $clog2(WORDS + 1);
    localparam int unsigned BCW   = $clog2(WORD_W + 1);
    localparam int unsigned PCW   = $clog2(WORD_W);

    localparam logic [CW-1:0]  LAST_BIT  = CW'(CHAIN_LEN - 1);
    localparam logic [WCW-1:0] WORDS_L   = WCW'(WORDS);
    localparam logic [BCW-1:0] FULL      = BCW'(WORD_W);
    localparam logic [PCW-1:0] PACK_LAST = PCW'(WORD_W - 1);

    state_t            state, state_nx;
    logic              op_r;
    logic [CW-1:0]     bit_cnt;
    logic [WCW-1:0]    word_cnt;
    logic [WORD_W-1:0] in_buf;
    logic [BCW-1:0]    in_bits;
    logic [WORD_W-2:0] cap_sr;
    logic [PCW-1:0]    cap_cnt;
    logic [WORD_W-1:0] out_data_r;
    logic              out_valid_r;
    logic              cfg_done_r;
    logic              done_r;

    logic se, in_rdy, cap_block, op_done, load_done, crc_ok;

    always_ff @(posedge CK or negedge R) begin
        if (!R) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        se        = 1'b0;
        in_rdy    = 1'b0;
        cap_block = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = SHIFT;
            end
            SHIFT: begin
                // Hold the bit that would complete a word while the previous word is still unread.
                cap_block = (op_r == OP_READBACK) && (cap_cnt == PACK_LAST) &&
                            out_valid_r && !host.out_ready;
                se        = (in_bits != '0) && !cap_block;
                in_rdy    = ((in_bits == '0) || ((in_bits == BCW'(1)) && se)) &&
                            (word_cnt != WORDS_L);
                if (se && (bit_cnt == LAST_BIT)) begin
                    state_nx = (op_r == OP_LOAD) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid_r && host.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    assign op_done   = !abort && (state != IDLE) && (state_nx == IDLE);
    assign load_done = op_done && (op_r == OP_LOAD);

    always_ff @(posedge CK or negedge R) begin
        if (!R) begin
            op_r        <= OP_LOAD;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            in_buf      <= '0;
            in_bits     <= '0;
            cap_sr      <= '0;
            cap_cnt     <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            cfg_done_r  <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= op_done;
            if (abort) begin
                bit_cnt     <= '0;
                word_cnt    <= '0;
                in_bits     <= '0;
                cap_cnt     <= '0;
                out_valid_r <= 1'b0;
                cfg_done_r  <= 1'b0;
            end else if (state == IDLE) begin
                if (start) begin
                    op_r       <= op;
                    bit_cnt    <= '0;
                    word_cnt   <= '0;
                    in_bits    <= '0;
                    cap_cnt    <= '0;
                    cfg_done_r <= 1'b0;
                end
            end else begin
                if (se) begin
                    in_buf  <= in_buf >> 1;
                    in_bits <= in_bits - 1'b1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (host.in_valid && in_rdy) begin
                    in_buf   <= host.in_data;
                    in_bits  <= FULL;
                    word_cnt <= word_cnt + 1'b1;
                end
                if (out_valid_r && host.out_ready) out_valid_r <= 1'b0;
                if (se && (op_r == OP_READBACK)) begin
                    cap_sr  <= {CHAIN_SO, cap_sr[WORD_W-2:1]};
                    cap_cnt <= cap_cnt + 1'b1;
                    if (cap_cnt == PACK_LAST) begin
                        out_data_r  <= {CHAIN_SO, cap_sr};
                        out_valid_r <= 1'b1;
                    end
                end
                if (load_done) cfg_done_r <= crc_ok;
            end
        end
    end

`ifdef RS_SCAN_CTRL_CRC_EN
    logic [15:0] crc_nx;
    logic [15:0] crc_exp_r;
    logic        err_r;
    logic        op_accept;

    assign op_accept = (state == IDLE) && start && !abort;

    rs_scan_crc16 u_crc (
        .clk      (CK),
        .rst_n    (R),
        .clr      (op_accept),
        .en       (se),
        .din      (SI),
        .crc_next (crc_nx)
    );

    // Completion happens on the final shift edge, so compare the post-update CRC.
    assign crc_ok = (crc_nx == crc_exp_r);

    always_ff @(posedge CK or negedge R) begin
        if (!R) begin
            crc_exp_r <= '0;
            err_r     <= 1'b0;
        end else if (op_accept) begin
            crc_exp_r <= crc_exp;
            err_r     <= 1'b0;
        end else if (load_done) begin
            err_r <= !crc_ok;
        end
    end

    assign err = err_r;
`else
    assign crc_ok = 1'b1;
    assign err    = 1'b0;
`endif

    assign SE             = se;
    assign SI             = se & in_buf[0];
    assign SCAN_MODE      = (state == SHIFT);
    assign busy           = (state != IDLE);
    assign done           = done_r;
    assign cfg_done       = cfg_done_r;
    assign host.in_ready  = in_rdy;
    assign host.out_data  = out_data_r;
    assign host.out_valid = out_valid_r;
endmodule

// File: tb/tb_rs_scan_ctrl.sv
// Scoreboard bench for rs_scan_ctrl with a 16-cell behavioural scan chain.
module tb_rs_scan_ctrl;
    import rs_scan_pkg::*;

    localparam int unsigned CL = 16;

    logic CK = 1'b0;
    logic R = 1'b0;
    logic start = 1'b0, op = 1'b0, abort = 1'b0;
    logic SE, SI, CHAIN_SO, SCAN_MODE, cfg_done, busy, done, err;
`ifdef RS_SCAN_CTRL_CRC_EN
    logic [15:0] crc_exp = '0;
`endif

    rs_scan_ctrl_if #(.WORD_W(8)) hif ();

    rs_scan_ctrl #(.CHAIN_LEN(CL), .WORD_W(8)) dut (
        .CK        (CK),
        .R         (R),
        .start     (start),
        .op        (op),
        .abort     (abort),
        .host      (hif),
        .SE        (SE),
        .SI        (SI),
        .CHAIN_SO  (CHAIN_SO),
        .SCAN_MODE (SCAN_MODE),
        .cfg_done  (cfg_done),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef RS_SCAN_CTRL_CRC_EN
        ,
        .crc_exp   (crc_exp)
`endif
    );

    always #5 CK = ~CK;

    // Behavioural chain: SI enters the first cell, CHAIN_SO is the last cell.
    logic [CL-1:0] chain = '0;
    logic [CL-1:0] preload_val = '0;
    logic          preload_req = 1'b0;
    assign CHAIN_SO = chain[0];
    always @(posedge CK) begin
        if (preload_req) chain <= preload_val;
        else if (SE)     chain <= {SI, chain[CL-1:1]};
    end

    bit          exp_si[$];
    logic [7:0]  exp_out[$];
    logic [1:0]  exp_done[$];
    int n_chk = 0, n_fail = 0;
    int se_cnt = 0, stall_cnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({SE, SI, SCAN_MODE, cfg_done, busy, done, err,
                    hif.in_ready, hif.out_valid, hif.out_data});
    endfunction

    always @(negedge CK) begin
        if (SE) begin
            se_cnt++;
            if (exp_si.size() == 0) chk("si_unexpected_bit", 32'(exp_si.size()), 32'd1);
            else                    chk("si_bit", 32'(SI), 32'(exp_si.pop_front()));
        end
        if (SCAN_MODE && !SE) stall_cnt++;
        if (hif.out_valid && hif.out_ready) begin
            if (exp_out.size() == 0) chk("out_unexpected_word", 32'(exp_out.size()), 32'd1);
            else                     chk("out_word", 32'(hif.out_data), 32'(exp_out.pop_front()));
        end
        if (done) begin
            if (exp_done.size() == 0) chk("done_unexpected", 32'(exp_done.size()), 32'd1);
            else                      chk("done_cfg_err", 32'({cfg_done, err}), 32'(exp_done.pop_front()));
        end
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        @(negedge CK);
        while (!hif.in_ready && t < 200) begin
            @(negedge CK);
            t++;
        end
        chk("in_ready_timeout", 32'(hif.in_ready), 32'd1);
    endtask

    task automatic start_op(logic o);
        op = o;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(logic [7:0] w, int unsigned gap);
        if (gap > 0) begin
            wait_ready();
            repeat (gap) @(posedge CK);
            #1;
        end
        hif.in_data  = w;
        hif.in_valid = 1'b1;
        for (int b = 0; b < 8; b++) exp_si.push_back(w[b]);
        wait_ready();
        tick();
        hif.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge CK);
        while (busy && t < 300) begin
            @(negedge CK);
            t++;
        end
        chk("op_timeout", 32'(busy), 32'd0);
        tick();
    endtask

    task automatic preload(logic [CL-1:0] v);
        preload_val = v;
        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
    endtask

    task automatic run_load(int unsigned gap, int exp_stall);
        int se0 = se_cnt, st0 = stall_cnt;
        exp_done.push_back(2'b10);
        start_op(OP_LOAD);
        send_word(8'hA5, 0);
        send_word(8'h3C, gap);
        wait_idle();
        chk("load_se_pulses", 32'(se_cnt - se0), 32'd16);
        chk("load_stalls", 32'(stall_cnt - st0), 32'(exp_stall));
        chk("load_chain", 32'(chain), 32'h3CA5);
        chk("load_cfg_done_held", 32'(cfg_done), 32'd1);
    endtask

    task automatic run_rb(int unsigned hold, int exp_stall);
        int se0, st0;
        preload(16'hBEEF);
        exp_out.push_back(8'hEF);
        exp_out.push_back(8'hBE);
        exp_done.push_back(2'b00);
        hif.out_ready = (hold == 0);
        se0 = se_cnt;
        st0 = stall_cnt;
        start_op(OP_READBACK);
        fork
            begin
                send_word(8'h00, 0);
                send_word(8'h00, 0);
            end
            begin
                if (hold > 0) begin
                    int t = 0;
                    @(negedge CK);
                    while (!hif.out_valid && t < 200) begin
                        @(negedge CK);
                        t++;
                    end
                    chk("out_valid_timeout", 32'(hif.out_valid), 32'd1);
                    repeat (hold) @(posedge CK);
                    #1;
                    hif.out_ready = 1'b1;
                end
            end
        join
        wait_idle();
        chk("rb_chain_cleared", 32'(chain), 32'h0000);
        chk("rb_se_pulses", 32'(se_cnt - se0), 32'd16);
        chk("rb_stalls", 32'(stall_cnt - st0), 32'(exp_stall));
    endtask

    task automatic run_to_bit7();
        int se0 = se_cnt;
        int t = 0;
        start_op(OP_LOAD);
        send_word(8'hA5, 0);
        while ((se_cnt - se0) < 7 && t < 200) begin
            tick();
            t++;
        end
        chk("bit7_reached", 32'(se_cnt - se0 >= 7), 32'd1);
    endtask

`ifdef RS_SCAN_CTRL_CRC_EN
    function automatic logic [15:0] crc_model(logic [15:0] bits);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ bits[i]) ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hif.in_data   = '0;
        hif.in_valid  = 1'b0;
        hif.out_ready = 1'b1;
`ifdef RS_SCAN_CTRL_CRC_EN
        crc_exp = crc_model(16'h3CA5);
`endif
        #2;
        chk("reset_outputs", outs(), 32'd0);
        #13;
        R = 1'b1;
        tick();
        chk("idle_after_reset", outs(), 32'd0);

        run_load(0, 1);
        run_load(3, 4);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge CK);
        chk("abort_idle_clears_cfg_done", 32'(cfg_done), 32'd0);
        tick();

        run_rb(0, 1);
        run_rb(5, 1);
        run_rb(12, 6);

        run_to_bit7();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_si.delete();
        @(negedge CK);
        chk("abort_outputs", 32'(outs() >> 8), 32'd0);
        repeat (4) tick();
        run_load(0, 1);

        run_to_bit7();
        R = 1'b0;
        #1;
        chk("reset_midop_outputs", outs(), 32'd0);
        exp_si.delete();
        tick();
        @(negedge CK);
        R = 1'b1;
        repeat (3) tick();
        chk("reset_release_idle", outs(), 32'd0);
        run_load(0, 1);

`ifdef RS_SCAN_CTRL_CRC_EN
        crc_exp = crc_model(16'h3CA5) ^ 16'h0001;
        exp_done.push_back(2'b01);
        start_op(OP_LOAD);
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        wait_idle();
        chk("crc_bad_err", 32'({cfg_done, err}), 32'h1);
        crc_exp = crc_model(16'h3CA5);
        run_load(0, 1);
        chk("crc_good_err_clear", 32'(err), 32'd0);
`endif

        repeat (3) tick();
        chk("si_queue_empty", 32'(exp_si.size()), 32'd0);
        chk("out_queue_empty", 32'(exp_out.size()), 32'd0);
        chk("done_queue_empty", 32'(exp_done.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
